// File: rtl/conv_filter_param_if.sv
// rtl/conv_filter_param_if.sv - window/coefficient/result bundle for the K x K convolution engine
interface conv_filter_param_if #(
    parameter int KERNEL_SIZE = 5,
    parameter int PIXEL_W     = 8,
    parameter int COEFF_W     = 8,
    parameter int ADDR_W      = 6
);
    logic [KERNEL_SIZE*KERNEL_SIZE*PIXEL_W-1:0] pixel_data;
    logic                                       pixel_data_valid;
    logic                                       coeff_wr_en;
    logic [ADDR_W-1:0]                          coeff_addr;
    logic [COEFF_W-1:0]                         coeff_wr_data;
    logic [4:0]                                 cfg_shift;
    logic                                       cfg_abs;
    logic                                       coeff_commit;
    logic [PIXEL_W-1:0]                         convolved_data;
    logic                                       convolved_data_valid;

    modport master (
        output pixel_data, pixel_data_valid, coeff_wr_en, coeff_addr, coeff_wr_data,
               cfg_shift, cfg_abs, coeff_commit,
        input  convolved_data, convolved_data_valid
    );

    modport slave (
        input  pixel_data, pixel_data_valid, coeff_wr_en, coeff_addr, coeff_wr_data,
               cfg_shift, cfg_abs, coeff_commit,
        output convolved_data, convolved_data_valid
    );
endinterface

// File: rtl/conv_filter_param.sv
// rtl/conv_filter_param.sv - K x K signed-coefficient convolution with shadow bank, shift, abs/clamp, saturation
module conv_filter_param #(
    parameter int KERNEL_SIZE = 5,
    parameter int PIXEL_W     = 8,
    parameter int COEFF_W     = 8,
    parameter int ADDR_W      = 6
) (
    input logic                clk,
    input logic                reset,
    conv_filter_param_if.slave bus
);
    localparam int N      = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CENTRE = (N - 1) / 2;
    localparam int IDX_W  = $clog2(N);
    localparam int PROD_W = PIXEL_W + COEFF_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(N);
    localparam logic [PIXEL_W-1:0] PIX_MAX = '1;

    logic signed [COEFF_W-1:0] shadow_bank [N];
    logic signed [COEFF_W-1:0] active_bank [N];
    logic [4:0]                act_shift;
    logic                      act_abs;

    logic signed [PROD_W-1:0]  s1_prod [N];
    logic                      s1_valid;
    logic [4:0]                s1_shift;
    logic                      s1_abs;

    logic signed [ACC_W-1:0]   s2_sum;
    logic                      s2_valid;
    logic [4:0]                s2_shift;
    logic                      s2_abs;

    logic signed [ACC_W-1:0]   sum_c;
    logic signed [ACC_W-1:0]   shifted_c;
    logic signed [ACC_W-1:0]   mag_c;
    logic [PIXEL_W-1:0]        result_c;

    // Shadow writes and atomic commit; commit copies the pre-write shadow contents
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                shadow_bank[i] <= (i == CENTRE) ? COEFF_W'(1) : '0;
                active_bank[i] <= (i == CENTRE) ? COEFF_W'(1) : '0;
            end
            act_shift <= '0;
            act_abs   <= 1'b0;
        end else begin
            if (bus.coeff_wr_en && (32'(bus.coeff_addr) < N)) begin
                shadow_bank[bus.coeff_addr[IDX_W-1:0]] <= bus.coeff_wr_data;
            end
            if (bus.coeff_commit) begin
                for (int i = 0; i < N; i++) begin
                    active_bank[i] <= shadow_bank[i];
                end
                act_shift <= bus.cfg_shift;
                act_abs   <= bus.cfg_abs;
            end
        end
    end

    // S1: per-tap products; shift/abs captured here so in-flight windows ignore later commits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_shift <= '0;
            s1_abs   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                s1_prod[i] <= '0;
            end
        end else begin
            s1_valid <= bus.pixel_data_valid;
            if (bus.pixel_data_valid) begin
                for (int i = 0; i < N; i++) begin
                    s1_prod[i] <= PROD_W'($signed({1'b0, bus.pixel_data[PIXEL_W*i +: PIXEL_W]}))
                                * PROD_W'(active_bank[i]);
                end
                s1_shift <= act_shift;
                s1_abs   <= act_abs;
            end
        end
    end

    // Sign-extended sum of all products; accumulator is wide enough that it cannot overflow
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < N; i++) begin
            sum_c = sum_c + ACC_W'(s1_prod[i]);
        end
    end

    // S2: register the sum together with its window's shift/abs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_shift <= '0;
            s2_abs   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum   <= sum_c;
                s2_shift <= s1_shift;
                s2_abs   <= s1_abs;
            end
        end
    end

    // Floor shift (large shifts collapse to 0 or -1), then abs/clamp, then saturate
    always_comb begin
        shifted_c = s2_sum >>> s2_shift;
        if (shifted_c[ACC_W-1]) begin
            mag_c = s2_abs ? -shifted_c : '0;
        end else begin
            mag_c = shifted_c;
        end
        if (mag_c > ACC_W'(PIX_MAX)) begin
            result_c = PIX_MAX;
        end else begin
            result_c = mag_c[PIXEL_W-1:0];
        end
    end

    // S3: output register; data holds across gaps in valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.convolved_data       <= '0;
            bus.convolved_data_valid <= 1'b0;
        end else begin
            bus.convolved_data_valid <= s2_valid;
            if (s2_valid) begin
                bus.convolved_data <= result_c;
            end
        end
    end
endmodule

// File: tb/tb_conv_filter_param.sv
// tb/tb_conv_filter_param.sv - directed table-driven bench for conv_filter_param
module tb_conv_filter_param;
    localparam int K  = 5;
    localparam int PW = 8;
    localparam int CW = 8;
    localparam int AW = 6;
    localparam int N  = K * K;
    localparam int CENTRE = 12;

    typedef struct {
        string name;
        int    cc;
        int    co;
        int    sh;
        int    ab;
        int    pc;
        int    po;
        int    exp;
    } vec_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    vec_t vecs [13];
    int   pat  [6];
    int   expa [6];

    conv_filter_param_if #(.KERNEL_SIZE(K), .PIXEL_W(PW), .COEFF_W(CW), .ADDR_W(AW)) bus ();

    conv_filter_param #(.KERNEL_SIZE(K), .PIXEL_W(PW), .COEFF_W(CW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pixel_data       = '0;
        bus.pixel_data_valid = 1'b0;
        bus.coeff_wr_en      = 1'b0;
        bus.coeff_addr       = '0;
        bus.coeff_wr_data    = '0;
        bus.cfg_shift        = '0;
        bus.cfg_abs          = 1'b0;
        bus.coeff_commit     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic set_window(input int pc, input int po);
        for (int i = 0; i < N; i++) begin
            bus.pixel_data[PW*i +: PW] = PW'((i == CENTRE) ? pc : po);
        end
    endtask

    task automatic program_kernel(input int cc, input int co, input int sh, input int ab);
        for (int i = 0; i < N; i++) begin
            bus.coeff_wr_en   = 1'b1;
            bus.coeff_addr    = AW'(i);
            bus.coeff_wr_data = CW'((i == CENTRE) ? cc : co);
            tick();
        end
        bus.coeff_wr_en  = 1'b0;
        bus.cfg_shift    = 5'(sh);
        bus.cfg_abs      = ab[0];
        bus.coeff_commit = 1'b1;
        tick();
        bus.coeff_commit = 1'b0;
    endtask

    task automatic apply_window(input int pc, input int po, input int exp, input string name);
        set_window(pc, po);
        bus.pixel_data_valid = 1'b1;
        tick();
        bus.pixel_data_valid = 1'b0;
        check({name, "_v0"}, int'(bus.convolved_data_valid), 0);
        tick();
        check({name, "_v1"}, int'(bus.convolved_data_valid), 0);
        tick();
        check({name, "_v2"}, int'(bus.convolved_data_valid), 1);
        check({name, "_data"}, int'(bus.convolved_data), exp);
        tick();
        check({name, "_v3"}, int'(bus.convolved_data_valid), 0);
        check({name, "_hold"}, int'(bus.convolved_data), exp);
    endtask

    initial begin
        int last;
        int idx;
        int expb;

        n_chk = 0;
        n_err = 0;
        vecs[0]  = '{"box_10",      1,    1,   0, 0, 10,  10,  250};
        vecs[1]  = '{"box_20_sat",  1,    1,   0, 0, 20,  20,  255};
        vecs[2]  = '{"box_sh4",     1,    1,   4, 0, 20,  20,  31};
        vecs[3]  = '{"sharp_flat",  24,   -1,  0, 0, 100, 100, 0};
        vecs[4]  = '{"sharp_ctr",   24,   -1,  0, 0, 200, 0,   255};
        vecs[5]  = '{"sharp_clamp", 24,   -1,  0, 0, 0,   10,  0};
        vecs[6]  = '{"sharp_abs",   24,   -1,  0, 1, 0,   10,  240};
        vecs[7]  = '{"sh31_abs",    24,   -1,  31, 1, 0,  10,  1};
        vecs[8]  = '{"sh31_clamp",  24,   -1,  31, 0, 0,  10,  0};
        vecs[9]  = '{"sh31_pos",    1,    1,   31, 0, 255, 255, 0};
        vecs[10] = '{"floor_abs",   -3,   0,   1, 1, 1,   0,   2};
        vecs[11] = '{"neg128_sh8",  -128, 0,   8, 1, 255, 0,   128};
        vecs[12] = '{"max_sh13",    127,  127, 13, 0, 255, 255, 98};
        pat  = '{1, 0, 1, 1, 0, 1};
        expa = '{75, 81, 87, 93, 100, 106};

        idle_inputs();
        reset = 1'b0;
        #3;
        check("reset_valid", int'(bus.convolved_data_valid), 0);
        check("reset_data", int'(bus.convolved_data), 0);
        tick();
        tick();
        reset = 1'b1;

        apply_window(42, 7, 42, "identity");

        for (int v = 0; v < 13; v++) begin
            program_kernel(vecs[v].cc, vecs[v].co, vecs[v].sh, vecs[v].ab);
            apply_window(vecs[v].pc, vecs[v].po, vecs[v].exp, vecs[v].name);
        end

        // Valid gaps reproduced with incrementing windows, box kernel with shift 2
        program_kernel(1, 1, 2, 0);
        last = 0;
        for (int j = 0; j < 9; j++) begin
            if (j < 6) begin
                for (int i = 0; i < N; i++) bus.pixel_data[PW*i +: PW] = PW'(j + i);
                bus.pixel_data_valid = pat[j][0];
            end else begin
                bus.pixel_data_valid = 1'b0;
            end
            tick();
            if (j >= 2) begin
                idx = j - 2;
                if (idx < 6 && pat[idx] == 1) last = expa[idx];
                check($sformatf("gap_valid_%0d", j), int'(bus.convolved_data_valid),
                      (idx < 6) ? pat[idx] : 0);
                check($sformatf("gap_data_%0d", j), int'(bus.convolved_data), last);
            end
        end

        // Commit timing on a continuous stream, starting from identity
        do_reset();
        set_window(10, 10);
        for (int c = 0; c < 41; c++) begin
            bus.pixel_data_valid = (c < 38);
            bus.coeff_wr_en      = 1'b0;
            bus.coeff_commit     = 1'b0;
            if (c < N) begin
                bus.coeff_wr_en   = 1'b1;
                bus.coeff_addr    = AW'(c);
                bus.coeff_wr_data = CW'(1);
            end else if (c == 25 || c == 26) begin
                bus.coeff_wr_en   = 1'b1;
                bus.coeff_addr    = (c == 25) ? AW'(30) : AW'(44);
                bus.coeff_wr_data = CW'(0);
            end else if (c == 28) begin
                bus.coeff_wr_en   = 1'b1;
                bus.coeff_addr    = AW'(CENTRE);
                bus.coeff_wr_data = CW'(-100);
                bus.coeff_commit  = 1'b1;
            end else if (c == 32) begin
                bus.coeff_commit  = 1'b1;
            end
            tick();
            if (c >= 2) begin
                idx = c - 2;
                expb = (idx <= 28) ? 10 : (idx <= 32) ? 250 : 0;
                check($sformatf("commit_valid_%0d", c), int'(bus.convolved_data_valid),
                      (idx < 38) ? 1 : 0);
                if (idx < 38) begin
                    check($sformatf("commit_data_%0d", c), int'(bus.convolved_data), expb);
                end
            end
        end
        idle_inputs();

        // Reset mid-stream with windows in flight
        do_reset();
        apply_window(77, 0, 77, "pre_rst");
        set_window(33, 0);
        bus.pixel_data_valid = 1'b1;
        tick();
        tick();
        tick();
        check("inflight_valid", int'(bus.convolved_data_valid), 1);
        check("inflight_data", int'(bus.convolved_data), 33);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_valid", int'(bus.convolved_data_valid), 0);
        check("async_rst_data", int'(bus.convolved_data), 0);
        bus.pixel_data_valid = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            check($sformatf("no_stale_%0d", j), int'(bus.convolved_data_valid), 0);
        end
        apply_window(55, 3, 55, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/conv_filter_param.md
Name: conv_filter_param

Overview:
Parametrised K x K convolution engine, successor to the fixed 5x5 fir_filter. It sits after the line-buffer window generator and before the output formatter.
- Accepts one flattened pixel window per cycle and produces one filtered pixel per window.
- Coefficients are signed, runtime-programmable and double-buffered through a shadow bank with an atomic commit.
- Adds programmable normalisation shift, absolute-value/clamp mode and output saturation.

Parameters:
KERNEL_SIZE, 5, window edge K; odd, legal range 3..7
PIXEL_W, 8, unsigned pixel width
COEFF_W, 8, signed two's-complement coefficient width
ADDR_W, 6, coefficient address width; must satisfy 2^ADDR_W >= K*K

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
pixel_data  in  K*K*PIXEL_W  window; pixel i = row*K+col at [PIXEL_W*i +: PIXEL_W]
pixel_data_valid  in  1  window valid this cycle
coeff_wr_en  in  1  write coeff_wr_data into shadow bank
coeff_addr  in  ADDR_W  shadow coefficient index 0..K*K-1
coeff_wr_data  in  COEFF_W  signed coefficient
cfg_shift  in  5  normalisation right-shift amount, latched on commit
cfg_abs  in  1  1 = absolute value, 0 = clamp negatives to 0; latched on commit
coeff_commit  in  1  copy shadow bank + cfg_shift + cfg_abs into active bank
convolved_data  out  PIXEL_W  filtered pixel
convolved_data_valid  out  1  convolved_data valid this cycle

Behaviour:
Reset (reset = 0, asynchronous):
- convolved_data = 0 and convolved_data_valid = 0 immediately.
- Internal valid pipeline cleared.
- Active and shadow banks both load the identity kernel: centre index (K*K-1)/2 = 1, all others 0; shift = 0, abs = 0.

Pipeline: 3 register stages, no backpressure, one window accepted per cycle.
- S1: K*K products pixel(unsigned, zero-extended by 1 bit) x coeff(signed), each PIXEL_W+COEFF_W+1 bits.
- S2: adder-tree sum, width PIXEL_W+COEFF_W+1+clog2(K*K); no overflow is possible.
- S3: arithmetic right shift by active shift (floor). Then abs or clamp-to-0 per active abs. Then saturate to 2^PIXEL_W-1. Result registered to convolved_data.
- Valid shifts alongside the data. A window sampled at edge t produces its output with valid high after edge t+2 (3-cycle latency).
- Gaps in pixel_data_valid are reproduced exactly, delayed 3 cycles.
- When valid is low, S1-S3 data regs hold their previous values; convolved_data holds its last value.

Coefficient path:
- coeff_wr_en writes the shadow bank only. Writes with coeff_addr >= K*K are ignored.
- coeff_commit copies shadow, cfg_shift and cfg_abs to the active set at that edge.
- A window sampled on the same edge as the commit uses the OLD set; windows sampled from the next edge onward use the new set.
- Windows already in flight are unaffected by a commit; products are taken in S1 and shift/abs are carried per stage alongside valid.
- Simultaneous coeff_wr_en and coeff_commit: the commit copies the shadow value from before the write; the write lands in shadow only.
- Shift >= accumulator width yields 0 for non-negative sums and -1 for negative sums. The -1 becomes 1 in abs mode and 0 in clamp mode.

Reset mid-stream: all in-flight windows are discarded and no valid is emitted for them. After reset deasserts, output resumes 3 cycles after the next valid window, using the identity kernel.

Test Plan:
- Identity after reset, K=5: all pixels 7, centre 42, valid one cycle -> 3 cycles later convolved_data=42, valid high for exactly one cycle.
- Box kernel: write 25x coeff 1, shift 0, commit. Window all 10 -> 250. Window all 20 -> 255 (saturated). Commit shift 4, window all 20 -> 31.
- Signed/mode: centre 24, others -1. Uniform 100 -> 0. Centre 200, rest 0 -> 255. Centre 0, rest 10 -> 0 with cfg_abs=0 and 240 with cfg_abs=1.
- Valid pattern 1,0,1,1,0,1 with incrementing windows -> identical valid pattern delayed 3 cycles, data matches a golden model per window.
- Commit timing: stream continuous windows of all 10; write box kernel to shadow with no commit -> outputs stay 10. Commit at edge t -> window sampled at t gives 10, window at t+1 gives 250. Also write at out-of-range address 30 -> no effect.
- Reset assertion with 3 windows in flight -> outputs 0 at once, no stale valids after release. Post-reset window centre 55 -> 55.
